mux_scan_n_to_1: RTL and testbench
==================================

MUX_SCAN_N_TO_1 -- requirements
Module: mux_scan_n_to_1

Interface
REQ-001 Parameter N, default 4, number of input channels; SHALL be >= 2.
REQ-002 Parameter W, default 1, data width per channel in bits; SHALL be >= 1.
REQ-003 Parameter DWELL, default 4, samples taken per channel before scan advances; SHALL be >= 1.
REQ-004 Derived constant SW = max(1, clog2(N)), select/index width; SHALL NOT be overridable.
REQ-005 clk  input  1  rising-edge clock; one clock domain; all state changes on posedge clk.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 d  input  N*W  flattened data inputs; channel i at d[i*W +: W].
REQ-008 sel  input  SW  channel select, used in direct mode only.
REQ-009 mode  input  1  0 = direct select, 1 = auto-scan.
REQ-010 en  input  1  sample request.
REQ-011 y  output  W  registered selected data.
REQ-012 y_ch  output  SW  channel index that produced y.
REQ-013 y_valid  output  1  y/y_ch hold an unaccepted sample.
REQ-014 y_ready  input  1  downstream accepts y when y_valid & y_ready.
REQ-015 err  output  1  sticky flag: out-of-range sel seen.

Function
REQ-016 Internal state: ptr (SW bits, scan channel), cnt (dwell counter, clog2(DWELL+1) bits), mode_q (mode from previous cycle).
REQ-017 Two states: EMPTY (y_valid=0) and FULL (y_valid=1); state is y_valid itself.
REQ-018 Load condition: load = en & (~y_valid | y_ready) & in-range source channel.
REQ-019 Source channel: direct mode -> sel; scan mode -> ptr.
REQ-020 On load, next cycle: y = d[src*W +: W], y_ch = src, y_valid = 1; latency exactly 1 clock from en to y_valid.
REQ-021 EMPTY -> FULL on load; FULL -> FULL on load with y_ready (accept and reload same cycle, no bubble).
REQ-022 FULL -> EMPTY when y_ready & ~load; FULL with y_ready=0 holds y, y_ch, y_valid unchanged regardless of d, sel, en.
REQ-023 Direct mode, sel >= N: no load, err set to 1 next cycle, y_valid follows REQ-022 as if en=0.
REQ-024 err cleared only by rst.
REQ-025 Scan mode: each load increments cnt; when cnt reaches DWELL-1 on a load, cnt -> 0 and ptr -> ptr+1, wrapping N-1 -> 0.
REQ-026 ptr and cnt change only on scan-mode loads; stalls (y_valid & ~y_ready) freeze them.
REQ-027 Rising edge of mode (mode=1, mode_q=0): ptr and cnt forced to 0 that cycle; first scan sample, if loaded that cycle, is channel 0.
REQ-028 Direct-mode loads and mode=0 cycles do not alter ptr or cnt.
REQ-029 d is sampled only at the load edge; changes while FULL and stalled SHALL NOT appear on y.
REQ-030 DWELL=1: ptr advances on every scan load.

Reset
REQ-031 While rst=1 at posedge: y=0, y_ch=0, y_valid=0, err=0, ptr=0, cnt=0, mode_q=0; rst overrides every other input.
REQ-032 Reset mid-transfer discards the held sample; y_valid low the cycle after rst edge, no accept reported.
REQ-033 First load possible on the first posedge with rst=0.

Verification
REQ-034 N=4,W=8, direct, d={8'h44,8'h33,8'h22,8'h11}, sel=2, en=1, y_ready=1 one cycle -> next cycle y=8'h33, y_ch=2, y_valid=1; following cycle y_valid=0.
REQ-035 Stall: load ch1, hold y_ready=0 for 5 cycles while changing d and sel -> y, y_ch stable, y_valid=1 throughout; y_ready=1 with en=0 -> y_valid=0 next cycle.
REQ-036 Scan, N=4, DWELL=2, en=1, y_ready=1 continuous from mode rising edge -> y_ch sequence 0,0,1,1,2,2,3,3,0,0 back-to-back with no bubble.
REQ-037 Scan with y_ready toggling 1,0,1,0 -> y_ch sequence still 0,0,1,1,...; no channel skipped or repeated beyond DWELL.
REQ-038 N=3, direct, sel=3, en=1 -> no load, y_valid stays 0, err=1 next cycle and stays 1 until rst; rst while FULL -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mux_scan_n_to_1_if.sv
// rtl/mux_scan_n_to_1_if.sv - channel data, control and output handshake bundle for mux_scan_n_to_1
interface mux_scan_n_to_1_if #(
   parameter int N = 4,
   parameter int W = 1
);
   localparam int SW = ($clog2(N) > 1) ? $clog2(N) : 1;

   logic [N*W-1:0] d;
   logic [SW-1:0]  sel;
   logic           mode;
   logic           en;
   logic [W-1:0]   y;
   logic [SW-1:0]  y_ch;
   logic           y_valid;
   logic           y_ready;
   logic           err;

   modport master (
      output d, sel, mode, en, y_ready,
      input  y, y_ch, y_valid, err
   );

   modport slave (
      input  d, sel, mode, en, y_ready,
      output y, y_ch, y_valid, err
   );
endinterface

// File: rtl/mux_scan_n_to_1.sv
// rtl/mux_scan_n_to_1.sv - registered N:1 mux with direct select or dwell-based auto-scan
module mux_scan_n_to_1 #(
   parameter int N     = 4,
   parameter int W     = 1,
   parameter int DWELL = 4
) (
   input logic               clk,
   input logic               rst,
   mux_scan_n_to_1_if.slave  bus
);
   localparam int SW = ($clog2(N) > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(DWELL + 1);

   localparam logic [SW:0]   N_EXT    = (SW + 1)'(N);
   localparam logic [SW-1:0] LAST_CH  = SW'(N - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]    state;
   logic [W-1:0]  y_q;
   logic [SW-1:0] y_ch_q;
   logic          err_q;
   logic [SW-1:0] ptr;
   logic [CW-1:0] cnt;
   logic          mode_q;

   logic          mode_rise;
   logic [SW-1:0] ptr_base;
   logic [CW-1:0] cnt_base;
   logic [SW-1:0] src;
   logic [SW-1:0] src_idx;
   logic          in_range;
   logic          load;
   logic          can_take;
   logic [W-1:0]  src_data;

   // A rising mode edge restarts the scan, so the current cycle already sees ptr/cnt as zero.
   always_comb begin
      mode_rise = bus.mode & ~mode_q;
      ptr_base  = mode_rise ? '0 : ptr;
      cnt_base  = mode_rise ? '0 : cnt;
      src       = bus.mode ? ptr_base : bus.sel;
      in_range  = ({1'b0, src} < N_EXT);
      src_idx   = in_range ? src : '0;
      can_take  = (state == EMPTY) | bus.y_ready;
      load      = bus.en & can_take & in_range;
      src_data  = bus.d[src_idx*W +: W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= EMPTY;
         y_q    <= '0;
         y_ch_q <= '0;
         err_q  <= 1'b0;
         ptr    <= '0;
         cnt    <= '0;
         mode_q <= 1'b0;
      end else begin
         mode_q <= bus.mode;

         if (load) begin
            state  <= FULL;
            y_q    <= src_data;
            y_ch_q <= src_idx;
         end else if (bus.y_ready) begin
            state  <= EMPTY;
         end

         if (~bus.mode & bus.en & ~in_range)
            err_q <= 1'b1;

         // Scan position only moves on scan loads; direct loads and stalls leave it alone.
         if (bus.mode & load) begin
            if (cnt_base == LAST_CNT) begin
               cnt <= '0;
               ptr <= (ptr_base == LAST_CH) ? '0 : ptr_base + 1'b1;
            end else begin
               cnt <= cnt_base + 1'b1;
               ptr <= ptr_base;
            end
         end else if (mode_rise) begin
            cnt <= '0;
            ptr <= '0;
         end
      end
   end

   assign bus.y       = y_q;
   assign bus.y_ch    = y_ch_q;
   assign bus.y_valid = state[0];
   assign bus.err     = err_q;
endmodule

// File: tb/tb_mux_scan_n_to_1.sv
// tb/tb_mux_scan_n_to_1.sv - directed self-checking bench for mux_scan_n_to_1
module tb_mux_scan_n_to_1;
   logic clk;
   logic rst;

   int tests_run;
   int tests_failed;

   mux_scan_n_to_1_if #(.N(4), .W(8)) bus_a ();
   mux_scan_n_to_1_if #(.N(3), .W(8)) bus_b ();

   mux_scan_n_to_1 #(.N(4), .W(8), .DWELL(2)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.slave)
   );

   mux_scan_n_to_1 #(.N(3), .W(8), .DWELL(1)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] a_byte [4];
   int         seq_full [10];
   int         seq_tog  [5];
   int         seq_b    [4];
   int         k;

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      a_byte   = '{8'h11, 8'h22, 8'h33, 8'h44};
      seq_full = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
      seq_tog  = '{0, 0, 1, 1, 2};
      seq_b    = '{0, 1, 2, 0};

      rst = 1'b1;
      bus_a.d = 32'h44332211; bus_a.sel = '0; bus_a.mode = 1'b0; bus_a.en = 1'b0; bus_a.y_ready = 1'b0;
      bus_b.d = 24'h332211;   bus_b.sel = '0; bus_b.mode = 1'b0; bus_b.en = 1'b0; bus_b.y_ready = 1'b0;
      tick;
      tick;
      rst = 1'b0;
      check("rst_y",       32'(bus_a.y),       32'h0);
      check("rst_y_ch",    32'(bus_a.y_ch),    32'h0);
      check("rst_y_valid", 32'(bus_a.y_valid), 32'h0);
      check("rst_err",     32'(bus_a.err),     32'h0);

      // direct select, single cycle
      bus_a.sel = 2'd2; bus_a.en = 1'b1; bus_a.y_ready = 1'b1;
      tick;
      bus_a.en = 1'b0;
      check("dir_y",       32'(bus_a.y),       32'h33);
      check("dir_y_ch",    32'(bus_a.y_ch),    32'd2);
      check("dir_y_valid", 32'(bus_a.y_valid), 32'd1);
      tick;
      check("dir_drain",   32'(bus_a.y_valid), 32'd0);

      // stall: output frozen while d and sel move
      bus_a.sel = 2'd1; bus_a.en = 1'b1; bus_a.y_ready = 1'b0;
      tick;
      for (int i = 0; i < 5; i++) begin
         bus_a.d   = 32'hA0B0C0D0 + 32'(i * 32'h01010101);
         bus_a.sel = 2'(i);
         tick;
         check("stall_y",       32'(bus_a.y),       32'h22);
         check("stall_y_ch",    32'(bus_a.y_ch),    32'd1);
         check("stall_y_valid", 32'(bus_a.y_valid), 32'd1);
      end
      bus_a.y_ready = 1'b1; bus_a.en = 1'b0; bus_a.d = 32'h44332211;
      tick;
      check("stall_release", 32'(bus_a.y_valid), 32'd0);

      // scan with continuous ready, DWELL=2
      bus_a.mode = 1'b1; bus_a.en = 1'b1; bus_a.y_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick;
         check("scan_y_ch",    32'(bus_a.y_ch),    32'(seq_full[i]));
         check("scan_y",       32'(bus_a.y),       32'(a_byte[seq_full[i]]));
         check("scan_y_valid", 32'(bus_a.y_valid), 32'd1);
      end
      bus_a.mode = 1'b0; bus_a.en = 1'b0;
      tick;
      check("scan_drain", 32'(bus_a.y_valid), 32'd0);

      // scan restart on mode edge with ready toggling
      bus_a.mode = 1'b1; bus_a.en = 1'b1;
      k = 0;
      for (int i = 0; i < 12; i++) begin
         bus_a.y_ready = (i % 2 == 0);
         if (bus_a.y_valid && bus_a.y_ready) begin
            if (k < 5) check("tog_y_ch", 32'(bus_a.y_ch), 32'(seq_tog[k]));
            k++;
         end
         tick;
      end
      check("tog_accepts", 32'(k), 32'd5);
      bus_a.mode = 1'b0; bus_a.en = 1'b0; bus_a.y_ready = 1'b1;
      tick;
      check("a_err_clean", 32'(bus_a.err), 32'd0);

      // N=3: direct load, then out-of-range select
      bus_b.sel = 2'd0; bus_b.en = 1'b1; bus_b.y_ready = 1'b1;
      tick;
      check("b_dir_y",   32'(bus_b.y),   32'h11);
      check("b_dir_err", 32'(bus_b.err), 32'd0);
      bus_b.sel = 2'd3;
      tick;
      check("b_oor_valid", 32'(bus_b.y_valid), 32'd0);
      check("b_oor_err",   32'(bus_b.err),     32'd1);
      bus_b.sel = 2'd0; bus_b.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         check("b_err_sticky", 32'(bus_b.err), 32'd1);
      end

      // DWELL=1 scan advances every load
      bus_b.mode = 1'b1; bus_b.en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         check("b_scan_y_ch", 32'(bus_b.y_ch), 32'(seq_b[i]));
         check("b_scan_y",    32'(bus_b.y),    32'(8'h11 + 8'(seq_b[i] * 8'h11)));
      end

      // reset while full discards the held sample
      bus_b.en = 1'b0; bus_b.y_ready = 1'b0; bus_b.mode = 1'b0;
      tick;
      check("b_full_hold", 32'(bus_b.y_valid), 32'd1);
      rst = 1'b1;
      tick;
      check("b_rst_y",       32'(bus_b.y),       32'h0);
      check("b_rst_y_ch",    32'(bus_b.y_ch),    32'h0);
      check("b_rst_y_valid", 32'(bus_b.y_valid), 32'h0);
      check("b_rst_err",     32'(bus_b.err),     32'h0);

      // first load on the first edge after reset
      rst = 1'b0; bus_b.sel = 2'd1; bus_b.en = 1'b1; bus_b.y_ready = 1'b1;
      tick;
      check("b_first_valid", 32'(bus_b.y_valid), 32'd1);
      check("b_first_y",     32'(bus_b.y),       32'h22);
      bus_b.en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
